// File: rtl/request_injector.sv
// Request injector: queues host requests in a small FIFO and issues them to the
// scheduler one at a time, with at least two idle cycles between issues.
module request_injector #(
    parameter int FIFO_AW = 3,
    parameter int CTRL_W  = 3,
    parameter int REQ_DW  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 host_vld,
    output logic                 host_rdy,
    input  logic [CTRL_W-1:0]    host_cmd,
    input  logic [REQ_DW-1:0]    host_data,
    input  logic                 flush,
    input  logic                 scheduler_rdy,
    output logic [0:CTRL_W-1]    request_control,
    output logic [0:REQ_DW-1]    request_data,
    output logic [FIFO_AW:0]     fifo_level,
    output logic [15:0]          issued_cnt,
    output logic                 nop_drop
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   FULL_LEVEL = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0]   LVL_ONE    = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_e;

    state_e                     state_q, state_d;
    logic [CTRL_W+REQ_DW-1:0]   mem_q [DEPTH];
    logic [FIFO_AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]           level_q, level_d;
    logic [15:0]                issued_cnt_q;
    logic                       nop_drop_q;
    logic [CTRL_W-1:0]          ctrl_q, ctrl_d;
    logic [REQ_DW-1:0]          data_q, data_d;
    logic [CTRL_W-1:0]          head_cmd;
    logic [REQ_DW-1:0]          head_data;
    logic                       handshake, push, pop, nop_seen, cnt_inc;

    assign host_rdy  = (level_q != FULL_LEVEL) && !flush;
    assign handshake = host_vld && host_rdy;
    assign push      = handshake && (host_cmd != '0);
    assign nop_seen  = handshake && (host_cmd == '0);
    assign {head_cmd, head_data} = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (level_q != '0 && scheduler_rdy && !flush) state_d = ISSUE;
            ISSUE:   state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The entry leaves the FIFO on the IDLE->ISSUE edge and is held in the output registers.
    always_comb begin
        pop     = (state_q == IDLE) && (state_d == ISSUE);
        cnt_inc = (state_q == ISSUE);
        ctrl_d  = '0;
        data_d  = '0;
        if (pop) begin
            ctrl_d = head_cmd;
            data_d = head_data;
        end
    end

    always_comb begin
        level_d = level_q;
        if (flush) begin
            level_d = '0;
        end else if (push && !pop) begin
            level_d = level_q + LVL_ONE;
        end else if (pop && !push) begin
            level_d = level_q - LVL_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {host_cmd, host_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            issued_cnt_q <= '0;
            nop_drop_q   <= 1'b0;
            ctrl_q       <= '0;
            data_q       <= '0;
        end else begin
            level_q <= level_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (cnt_inc)  issued_cnt_q <= issued_cnt_q + 16'd1;
            if (nop_seen) nop_drop_q   <= 1'b1;
        end
    end

    assign request_control = ctrl_q;
    assign request_data    = data_q;
    assign fifo_level      = level_q;
    assign issued_cnt      = issued_cnt_q;
    assign nop_drop        = nop_drop_q;
endmodule

// File: tb/tb_request_injector.sv
// Testbench for request_injector: hand-written vector table and corner sequences,
// plus random traffic checked against a queue-based reference model.
module tb_request_injector;
    localparam int DEPTH = 8;

    typedef struct {
        logic [2:0]  cmd;
        logic [31:0] data;
    } entry_t;

    typedef struct {
        logic        vld;
        logic [2:0]  cmd;
        logic [31:0] data;
        logic        fl;
        logic        srdy;
        logic        expRdy;
        logic [31:0] expCtrl;
        logic [31:0] expData;
        logic [31:0] expLevel;
        logic [31:0] expIssued;
        logic        expNop;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        hostVld;
    logic        hostRdy;
    logic [2:0]  hostCmd;
    logic [31:0] hostData;
    logic        flushIn;
    logic        schedRdy;
    logic [0:2]  reqCtrl;
    logic [0:31] reqData;
    logic [3:0]  fifoLevel;
    logic [15:0] issuedCnt;
    logic        nopDrop;

    int checks = 0;
    int errors = 0;

    entry_t      q[$];
    int          sinceIssue;
    logic [15:0] mIssued;
    logic        mNop;
    logic [31:0] mCtrl, mData;
    logic        mRdyPre;
    logic        rdySeen;
    vec_t        vecs[13];

    request_injector #(.FIFO_AW(3), .CTRL_W(3), .REQ_DW(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .host_vld       (hostVld),
        .host_rdy       (hostRdy),
        .host_cmd       (hostCmd),
        .host_data      (hostData),
        .flush          (flushIn),
        .scheduler_rdy  (schedRdy),
        .request_control(reqCtrl),
        .request_data   (reqData),
        .fifo_level     (fifoLevel),
        .issued_cnt     (issuedCnt),
        .nop_drop       (nopDrop)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        q.delete();
        sinceIssue = 3;
        mIssued    = 16'd0;
        mNop       = 1'b0;
        mCtrl      = 32'd0;
        mData      = 32'd0;
    endtask

    // An issue may start only once three cycles have passed since the previous start.
    task automatic modelStep();
        entry_t e;
        logic   rdy;
        logic   start;
        rdy   = (q.size() != DEPTH) && !flushIn;
        start = (sinceIssue >= 3) && (q.size() != 0) && schedRdy && !flushIn;
        if (sinceIssue == 1) mIssued = mIssued + 16'd1;
        if (start) begin
            e = q.pop_front();
            mCtrl = {29'd0, e.cmd};
            mData = e.data;
            sinceIssue = 1;
        end else begin
            mCtrl = 32'd0;
            mData = 32'd0;
            if (sinceIssue < 3) sinceIssue++;
        end
        if (flushIn) begin
            q.delete();
        end else if (hostVld && rdy) begin
            if (hostCmd != 3'd0) begin
                e.cmd  = hostCmd;
                e.data = hostData;
                q.push_back(e);
            end else begin
                mNop = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input logic vld, input logic [2:0] cmd, input logic [31:0] data,
                                 input logic fl, input logic srdy);
        hostVld  = vld;
        hostCmd  = cmd;
        hostData = data;
        flushIn  = fl;
        schedRdy = srdy;
        #1;
        rdySeen = hostRdy;
        mRdyPre = (q.size() != DEPTH) && !fl;
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic expRdy, input logic [31:0] expCtrl,
                               input logic [31:0] expData, input logic [31:0] expLevel,
                               input logic [31:0] expIssued, input logic expNop);
        checkVal({name, ".host_rdy"}, {31'd0, rdySeen}, {31'd0, expRdy});
        checkVal({name, ".request_control"}, {29'd0, reqCtrl}, expCtrl);
        checkVal({name, ".request_data"}, reqData, expData);
        checkVal({name, ".fifo_level"}, {28'd0, fifoLevel}, expLevel);
        checkVal({name, ".issued_cnt"}, {16'd0, issuedCnt}, expIssued);
        checkVal({name, ".nop_drop"}, {31'd0, nopDrop}, {31'd0, expNop});
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, mRdyPre, mCtrl, mData, q.size(), {16'd0, mIssued}, mNop);
    endtask

    initial begin
        logic [31:0] seenData[$];
        logic [15:0] issuedBefore;
        bit          found;

        vecs[0]  = '{1'b1, 3'd3, 32'h0000_00A5, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0,          32'd1, 32'd0, 1'b0};
        vecs[1]  = '{1'b0, 3'd0, 32'h0,         1'b0, 1'b1, 1'b1, 32'd3, 32'h0000_00A5, 32'd0, 32'd0, 1'b0};
        vecs[2]  = '{1'b0, 3'd0, 32'h0,         1'b0, 1'b1, 1'b1, 32'd0, 32'd0,          32'd0, 32'd1, 1'b0};
        vecs[3]  = '{1'b0, 3'd0, 32'h0,         1'b0, 1'b1, 1'b1, 32'd0, 32'd0,          32'd0, 32'd1, 1'b0};
        vecs[4]  = '{1'b1, 3'd0, 32'h0000_0055, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0,          32'd0, 32'd1, 1'b1};
        vecs[5]  = '{1'b0, 3'd0, 32'h0,         1'b0, 1'b1, 1'b1, 32'd0, 32'd0,          32'd0, 32'd1, 1'b1};
        vecs[6]  = '{1'b1, 3'd5, 32'h0000_1234, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0,          32'd1, 32'd1, 1'b1};
        vecs[7]  = '{1'b1, 3'd6, 32'h0000_BEEF, 1'b0, 1'b1, 1'b1, 32'd5, 32'h0000_1234, 32'd1, 32'd1, 1'b1};
        vecs[8]  = '{1'b0, 3'd0, 32'h0,         1'b0, 1'b1, 1'b1, 32'd0, 32'd0,          32'd1, 32'd2, 1'b1};
        vecs[9]  = '{1'b0, 3'd0, 32'h0,         1'b0, 1'b1, 1'b1, 32'd0, 32'd0,          32'd1, 32'd2, 1'b1};
        vecs[10] = '{1'b0, 3'd0, 32'h0,         1'b0, 1'b1, 1'b1, 32'd6, 32'h0000_BEEF, 32'd0, 32'd2, 1'b1};
        vecs[11] = '{1'b0, 3'd0, 32'h0,         1'b0, 1'b1, 1'b1, 32'd0, 32'd0,          32'd0, 32'd3, 1'b1};
        vecs[12] = '{1'b0, 3'd0, 32'h0,         1'b0, 1'b0, 1'b1, 32'd0, 32'd0,          32'd0, 32'd3, 1'b1};

        reset    = 1'b0;
        hostVld  = 1'b0;
        hostCmd  = 3'd0;
        hostData = 32'd0;
        flushIn  = 1'b0;
        schedRdy = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkVal("reset.request_control", {29'd0, reqCtrl}, 32'd0);
        checkVal("reset.fifo_level", {28'd0, fifoLevel}, 32'd0);
        checkVal("reset.issued_cnt", {16'd0, issuedCnt}, 32'd0);
        checkVal("reset.nop_drop", {31'd0, nopDrop}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].vld, vecs[i].cmd, vecs[i].data, vecs[i].fl, vecs[i].srdy);
            checkOutput($sformatf("vec%0d", i), vecs[i].expRdy, vecs[i].expCtrl, vecs[i].expData,
                        vecs[i].expLevel, vecs[i].expIssued, vecs[i].expNop);
        end

        // Fill past capacity while the scheduler stalls, then drain in order.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 3'((i % 7) + 1), 32'h1000 + 32'(i), 1'b0, 1'b0);
            checkModel($sformatf("fill%0d", i));
        end
        checkVal("full.host_rdy_9th", {31'd0, rdySeen}, 32'd0);
        checkVal("full.fifo_level", {28'd0, fifoLevel}, 32'd8);
        for (int i = 0; i < 27; i++) begin
            applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
            checkModel($sformatf("drain%0d", i));
            if (reqCtrl != 3'd0) seenData.push_back(reqData);
        end
        checkVal("drain.count", seenData.size(), 32'd8);
        for (int i = 0; i < seenData.size(); i++) begin
            checkVal($sformatf("drain.order%0d", i), seenData[i], 32'h1000 + 32'(i));
        end

        // Flush arriving while the first of four queued requests is being issued.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 3'd2, 32'h2000 + 32'(i), 1'b0, 1'b0);
        end
        issuedBefore = issuedCnt;
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
        checkModel("flush.start");
        checkVal("flush.issue_data", reqData, 32'h2000);
        applyStimulus(1'b1, 3'd4, 32'h3333, 1'b1, 1'b1);
        checkModel("flush.edge");
        checkVal("flush.fifo_level", {28'd0, fifoLevel}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
            checkModel($sformatf("flush.after%0d", i));
        end
        checkVal("flush.issued_delta", {16'd0, issuedCnt - issuedBefore}, 32'd1);

        // Issue counter wrap from 0xFFFF.
        force dut.issued_cnt_q = 16'hFFFF;
        #1;
        release dut.issued_cnt_q;
        mIssued = 16'hFFFF;
        applyStimulus(1'b1, 3'd1, 32'h4444, 1'b0, 1'b1);
        checkModel("wrap.push");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
            checkModel($sformatf("wrap.c%0d", i));
        end
        checkVal("wrap.issued_cnt", {16'd0, issuedCnt}, 32'd0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom,
                          $urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0);
            checkModel($sformatf("rand%0d", i));
        end

        // Asynchronous reset while a request is on the outputs.
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd7, 32'hDEAD, 1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (reqCtrl != 3'd0) found = 1'b1;
            else applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
        end
        checkVal("rstmid.reached_issue", {31'd0, found}, 32'd1);
        reset = 1'b0;
        #1;
        checkVal("rstmid.request_control", {29'd0, reqCtrl}, 32'd0);
        checkVal("rstmid.request_data", reqData, 32'd0);
        checkVal("rstmid.issued_cnt", {16'd0, issuedCnt}, 32'd0);
        checkVal("rstmid.nop_drop", {31'd0, nopDrop}, 32'd0);
        checkVal("rstmid.fifo_level", {28'd0, fifoLevel}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        modelReset();
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("rstmid.after", 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/request_injector.md
REQUEST_INJECTOR -- requirements
Module: request_injector

Interface
REQ-001 SHALL have parameter FIFO_AW, default 3, giving a request FIFO depth of 2^FIFO_AW entries.
REQ-002 SHALL have parameter CTRL_W, default 3, the request command width.
REQ-003 SHALL have parameter REQ_DW, default 32, the request payload width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port host_vld, input, 1 bit: the host offers a request this cycle.
REQ-007 SHALL have port host_rdy, output, 1 bit: the injector accepts the offered request this cycle.
REQ-008 SHALL have port host_cmd, input, CTRL_W bits: the request command; 0 is NOP.
REQ-009 SHALL have port host_data, input, REQ_DW bits: the request payload.
REQ-010 SHALL have port flush, input, 1 bit: synchronous discard of all queued requests.
REQ-011 SHALL have port scheduler_rdy, input, 1 bit: the downstream scheduler can take a request.
REQ-012 SHALL have port request_control, output, [0:CTRL_W-1]: command to the scheduler; bit 0 is the MSB.
REQ-013 SHALL have port request_data, output, [0:REQ_DW-1]: payload to the scheduler; bit 0 is the MSB.
REQ-014 SHALL have port fifo_level, output, FIFO_AW+1 bits: number of queued requests.
REQ-015 SHALL have port issued_cnt, output, 16 bits: requests issued since reset.
REQ-016 SHALL have port nop_drop, output, 1 bit: sticky flag set when a NOP command is offered.

Function
REQ-017 SHALL drive host_rdy = (fifo_level != 2^FIFO_AW) && !flush, using only registered state.
REQ-018 SHALL treat a handshake as host_vld && host_rdy, and on a handshake with host_cmd != 0 SHALL push {host_cmd, host_data}.
REQ-019 SHALL discard a handshake with host_cmd == 0, leave the FIFO unchanged, and set nop_drop until reset.
REQ-020 SHALL implement a three-state FSM with states IDLE, ISSUE and GAP.
REQ-021 SHALL move IDLE -> ISSUE when fifo_level != 0 && scheduler_rdy && !flush, popping the head entry on that edge.
REQ-022 SHALL, in ISSUE, present the popped entry for exactly one cycle: request_control equals the command value and request_data equals the payload.
REQ-023 SHALL move ISSUE -> GAP unconditionally and increment issued_cnt on that edge; issued_cnt wraps 0xFFFF -> 0.
REQ-024 SHALL move GAP -> IDLE unconditionally, so a new request issues at most once every 3 cycles.
REQ-025 SHALL drive request_control and request_data to 0 in IDLE and GAP, from registers with no combinational path from inputs.
REQ-026 SHALL, on a same-cycle push and pop, leave fifo_level unchanged and preserve FIFO order.
REQ-027 SHALL, on flush, clear fifo_level to 0 and reset the read and write pointers on the next edge, while ignoring host_vld.
REQ-028 SHALL let an ISSUE already in progress complete through GAP when flush arrives.
REQ-029 SHALL not start an issue when scheduler_rdy is low; the head entry is held indefinitely.
REQ-030 SHALL wrap the FIFO pointers modulo 2^FIFO_AW, and fifo_level SHALL never exceed 2^FIFO_AW.

Reset
REQ-031 SHALL, while reset is low, force the FSM to IDLE, fifo_level = 0, pointers = 0, request_control = 0, request_data = 0, issued_cnt = 0 and nop_drop = 0.
REQ-032 SHALL discard any in-flight request on reset mid-ISSUE, with outputs going to 0 asynchronously.
REQ-033 SHALL drive host_rdy = 1 on the first cycle after reset deasserts.

Verification
REQ-034 Single request: push cmd=3, data=0x0000_00A5 with scheduler_rdy=1 -> one cycle later request_control=3 and request_data=0xA5 for exactly 1 cycle; issued_cnt=1; fifo_level returns to 0.
REQ-035 Backpressure/full: scheduler_rdy=0, push 9 requests with FIFO_AW=3 -> 8 accepted, host_rdy=0 on the 9th, fifo_level=8; then raise scheduler_rdy -> 8 issues 3 cycles apart, in push order.
REQ-036 NOP: push cmd=0 -> fifo_level stays 0, nop_drop=1, no issue occurs.
REQ-037 Flush: queue 4 requests, assert flush in the cycle an issue starts -> that 1 request issues, fifo_level=0, issued_cnt=1.
REQ-038 Reset mid-ISSUE: assert reset low during ISSUE -> request_control=0 immediately; all counters are 0 after release.
REQ-039 Wrap: preload issued_cnt to 0xFFFF via 65535 issues (or force), then issue one more -> issued_cnt=0; pointers wrap with no loss of data.
